// File: rtl/simplez_pkg.sv
// Shared constants and the micro-order bundle for the SIMPLEZ hardwired control unit.
// Opcodes match RI[11:9]; state encodings are what appears on state_o.
package simplez_pkg;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [2:0] S_INI = 3'd0;
  localparam logic [2:0] S_I0  = 3'd1;
  localparam logic [2:0] S_I1  = 3'd2;
  localparam logic [2:0] S_O0  = 3'd3;
  localparam logic [2:0] S_O1  = 3'd4;
  localparam logic [2:0] S_HLT = 3'd5;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_DEC  = 2'd2;
  localparam logic [1:0] ALU_CLR  = 2'd3;

  typedef struct packed {
    logic       lec;
    logic       esc;
    logic       era;
    logic       eri;
    logic       sri;
    logic       scp;
    logic       incp;
    logic       ecp;
    logic       eac;
    logic       sac;
    logic [1:0] alu_op;
    logic       stop;
  } uorder_t;

  // Instructions that need a second memory access through RA = CD.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_ST) || (op == OP_LD) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/simplez_uorder_decode.sv
// Combinational heart of the sequencer: maps (state, opcode, z, mem_ready) to the
// micro-order vector and the next state.
module simplez_uorder_decode
  import simplez_pkg::*;
#(
  parameter bit USE_READY = 1'b1
) (
  input  logic [2:0] state,
  input  logic [2:0] co,
  input  logic       z,
  input  logic       mem_ready,
  output uorder_t    uo,
  output logic [2:0] next_state
);

  logic ready;

  assign ready = USE_READY ? mem_ready : 1'b1;

  always_comb begin
    uo         = '0;
    next_state = S_I0;
    case (state)
      S_INI: begin
        uo.scp     = 1'b1;
        uo.era     = 1'b1;
        next_state = S_I0;
      end
      S_I0: begin
        uo.lec = 1'b1;
        if (ready) begin
          uo.eri     = 1'b1;
          uo.incp    = 1'b1;
          next_state = S_I1;
        end else begin
          next_state = S_I0;
        end
      end
      S_I1: begin
        case (co)
          OP_ST, OP_LD, OP_ADD: begin
            uo.sri     = 1'b1;
            uo.era     = 1'b1;
            next_state = S_O0;
          end
          OP_BR: begin
            uo.sri = 1'b1;
            uo.era = 1'b1;
            uo.ecp = 1'b1;
          end
          // A not-taken BZ simply points RA back at the already-incremented CP.
          OP_BZ: begin
            uo.era = 1'b1;
            if (z) begin
              uo.sri = 1'b1;
              uo.ecp = 1'b1;
            end else begin
              uo.scp = 1'b1;
            end
          end
          OP_CLR: begin
            uo.eac    = 1'b1;
            uo.alu_op = ALU_CLR;
            uo.scp    = 1'b1;
            uo.era    = 1'b1;
          end
          OP_DEC: begin
            uo.eac    = 1'b1;
            uo.alu_op = ALU_DEC;
            uo.scp    = 1'b1;
            uo.era    = 1'b1;
          end
          default: begin
            uo.stop    = 1'b1;
            next_state = S_HLT;
          end
        endcase
      end
      S_O0: begin
        case (co)
          OP_ST: begin
            uo.sac = 1'b1;
            uo.esc = 1'b1;
          end
          OP_LD: begin
            uo.lec = 1'b1;
            if (ready) begin
              uo.eac    = 1'b1;
              uo.alu_op = ALU_PASS;
            end
          end
          OP_ADD: begin
            uo.lec = 1'b1;
            if (ready) begin
              uo.eac    = 1'b1;
              uo.alu_op = ALU_ADD;
            end
          end
          default: uo = '0;
        endcase
        if (is_mem_op(co)) begin
          next_state = ready ? S_O1 : S_O0;
        end else begin
          next_state = S_I0;
        end
      end
      S_O1: begin
        uo.scp     = 1'b1;
        uo.era     = 1'b1;
        next_state = S_I0;
      end
      S_HLT: begin
        uo.stop    = 1'b1;
        next_state = S_HLT;
      end
      default: begin
        uo         = '0;
        next_state = S_I0;
      end
    endcase
  end

endmodule

// File: rtl/simplez_control_unit.sv
// Hardwired SIMPLEZ sequencer: state register on the falling edge, opcode latched
// in I1, and every micro-order forced low while rstn is asserted.
module simplez_control_unit
  import simplez_pkg::*;
#(
  parameter bit USE_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] co,
  input  logic       z,
  input  logic       mem_ready,
  output logic       lec,
  output logic       esc,
  output logic       era,
  output logic       eri,
  output logic       sri,
  output logic       scp,
  output logic       incp,
  output logic       ecp,
  output logic       eac,
  output logic       sac,
  output logic [1:0] alu_op,
  output logic       stop,
  output logic [2:0] state_o
);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [2:0] op_q;
  logic [2:0] co_eff;
  uorder_t    uo;
  uorder_t    uo_gated;

  // RI may change while the operand phase runs, so O0 works from the opcode seen in I1.
  assign co_eff = (state == S_I1) ? co : op_q;

  simplez_uorder_decode #(
    .USE_READY(USE_READY)
  ) u_decode (
    .state     (state),
    .co        (co_eff),
    .z         (z),
    .mem_ready (mem_ready),
    .uo        (uo),
    .next_state(next_state)
  );

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_INI;
      op_q  <= OP_ST;
    end else begin
      state <= next_state;
      if (state == S_I1) begin
        op_q <= co;
      end
    end
  end

  // Combinational gating so a write strobe dies the instant reset is asserted.
  assign uo_gated = rstn ? uo : '0;

  assign lec     = uo_gated.lec;
  assign esc     = uo_gated.esc;
  assign era     = uo_gated.era;
  assign eri     = uo_gated.eri;
  assign sri     = uo_gated.sri;
  assign scp     = uo_gated.scp;
  assign incp    = uo_gated.incp;
  assign ecp     = uo_gated.ecp;
  assign eac     = uo_gated.eac;
  assign sac     = uo_gated.sac;
  assign alu_op  = uo_gated.alu_op;
  assign stop    = uo_gated.stop;
  assign state_o = rstn ? state : S_INI;

endmodule

// File: tb/tb_simplez_control_unit.sv
// Directed and random checks of the SIMPLEZ control unit; one instance waits on
// mem_ready, a second ignores it, both fed from the same stimulus.
module tb_simplez_control_unit;
  import simplez_pkg::*;

  localparam logic [12:0] LEC     = 13'h1000;
  localparam logic [12:0] ESC     = 13'h0800;
  localparam logic [12:0] ERA     = 13'h0400;
  localparam logic [12:0] ERI     = 13'h0200;
  localparam logic [12:0] SRI     = 13'h0100;
  localparam logic [12:0] SCP     = 13'h0080;
  localparam logic [12:0] INCP    = 13'h0040;
  localparam logic [12:0] ECP     = 13'h0020;
  localparam logic [12:0] EAC     = 13'h0010;
  localparam logic [12:0] SAC     = 13'h0008;
  localparam logic [12:0] AOP_ADD = 13'h0002;
  localparam logic [12:0] AOP_DEC = 13'h0004;
  localparam logic [12:0] AOP_CLR = 13'h0006;
  localparam logic [12:0] STOP    = 13'h0001;
  localparam logic [12:0] NONE    = 13'h0000;

  typedef struct {
    logic [2:0]  st;
    logic [12:0] vec;
    bit          chk_nr;
    logic [2:0]  nst;
    logic [12:0] nvec;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] co = 3'd0;
  logic       z = 1'b0;
  logic       mem_ready = 1'b0;

  logic       lec, esc, era, eri, sri, scp, incp, ecp, eac, sac, stop;
  logic [1:0] alu_op;
  logic [2:0] state_o;
  logic       n_lec, n_esc, n_era, n_eri, n_sri, n_scp, n_incp, n_ecp, n_eac, n_sac, n_stop;
  logic [1:0] n_alu_op;
  logic [2:0] n_state_o;

  logic [12:0] obs_vec;
  logic [12:0] obs_nvec;

  assign obs_vec  = {lec, esc, era, eri, sri, scp, incp, ecp, eac, sac, alu_op, stop};
  assign obs_nvec = {n_lec, n_esc, n_era, n_eri, n_sri, n_scp, n_incp, n_ecp, n_eac, n_sac,
                     n_alu_op, n_stop};

  always #5 clk = ~clk;

  simplez_control_unit #(.USE_READY(1'b1)) dut (
    .clk(clk), .rstn(rstn), .co(co), .z(z), .mem_ready(mem_ready),
    .lec(lec), .esc(esc), .era(era), .eri(eri), .sri(sri), .scp(scp),
    .incp(incp), .ecp(ecp), .eac(eac), .sac(sac), .alu_op(alu_op),
    .stop(stop), .state_o(state_o)
  );

  simplez_control_unit #(.USE_READY(1'b0)) dut_nr (
    .clk(clk), .rstn(rstn), .co(co), .z(z), .mem_ready(mem_ready),
    .lec(n_lec), .esc(n_esc), .era(n_era), .eri(n_eri), .sri(n_sri), .scp(n_scp),
    .incp(n_incp), .ecp(n_ecp), .eac(n_eac), .sac(n_sac), .alu_op(n_alu_op),
    .stop(n_stop), .state_o(n_state_o)
  );

  task automatic applyStimulus(input logic r, input logic [2:0] c, input logic zz,
                               input logic rdy, input exp_t e);
    @(negedge clk);
    #1;
    rstn      = r;
    co        = c;
    z         = zz;
    mem_ready = rdy;
    sb.push_back(e);
  endtask

  task automatic compareExp(input exp_t e);
    checks++;
    assert (state_o === e.st) else begin
      errors++;
      $error("[TB] FAIL %s state got %0d want %0d", e.tag, state_o, e.st);
    end
    checks++;
    assert (obs_vec === e.vec) else begin
      errors++;
      $error("[TB] FAIL %s uorders got %b want %b", e.tag, obs_vec, e.vec);
    end
    if (e.chk_nr) begin
      checks++;
      assert (n_state_o === e.nst) else begin
        errors++;
        $error("[TB] FAIL %s nr_state got %0d want %0d", e.tag, n_state_o, e.nst);
      end
      checks++;
      assert (obs_nvec === e.nvec) else begin
        errors++;
        $error("[TB] FAIL %s nr_uorders got %b want %b", e.tag, obs_nvec, e.nvec);
      end
    end
  endtask

  task automatic popAndCompare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      compareExp(e);
    end
  endtask

  task automatic checkOutput();
    @(posedge clk);
    popAndCompare();
  endtask

  task automatic step(input logic r, input logic [2:0] c, input logic zz, input logic rdy,
                      input logic [2:0] st, input logic [12:0] vec, input string tag,
                      input bit chk_nr = 1'b0, input logic [2:0] nst = 3'd0,
                      input logic [12:0] nvec = 13'd0);
    exp_t e;
    e.st     = st;
    e.vec    = vec;
    e.chk_nr = chk_nr;
    e.nst    = nst;
    e.nvec   = nvec;
    e.tag    = tag;
    applyStimulus(r, c, zz, rdy, e);
    checkOutput();
  endtask

  task automatic checkInvariants(input string tag, input logic [12:0] v, input logic [2:0] st);
    checks++;
    assert (!(v[6] && v[5])) else begin
      errors++; $error("[TB] FAIL %s incp_ecp got %b want not both", tag, v[6:5]);
    end
    checks++;
    assert (!(v[8] && v[7])) else begin
      errors++; $error("[TB] FAIL %s sri_scp got %b want not both", tag, v[8:7]);
    end
    checks++;
    assert (!(v[12] && v[11])) else begin
      errors++; $error("[TB] FAIL %s lec_esc got %b want not both", tag, v[12:11]);
    end
    checks++;
    assert (!v[3] || st == S_O0) else begin
      errors++; $error("[TB] FAIL %s sac_state got %0d want %0d", tag, st, S_O0);
    end
    checks++;
    assert (v[4] || v[2:1] == 2'd0) else begin
      errors++; $error("[TB] FAIL %s alu_idle got %0d want 0", tag, v[2:1]);
    end
  endtask

  initial begin
    exp_t e;

    step(1'b0, OP_LD, 1'b0, 1'b1, S_INI, NONE, "reset_state");
    step(1'b1, OP_LD, 1'b0, 1'b1, S_INI, SCP | ERA, "ld_ini");
    step(1'b1, OP_LD, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "ld_i0");
    step(1'b1, OP_LD, 1'b0, 1'b1, S_I1, SRI | ERA, "ld_i1");
    step(1'b1, OP_LD, 1'b0, 1'b1, S_O0, LEC | EAC, "ld_o0");
    step(1'b1, OP_LD, 1'b0, 1'b1, S_O1, SCP | ERA, "ld_o1");
    step(1'b1, OP_LD, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "ld_back_i0");

    step(1'b1, OP_BZ, 1'b1, 1'b1, S_I1, SRI | ERA | ECP, "bz_taken");
    step(1'b1, OP_BZ, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "bz_taken_next");
    step(1'b1, OP_BZ, 1'b0, 1'b1, S_I1, SCP | ERA, "bz_not_taken");
    step(1'b1, OP_BR, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "bz_not_taken_next");
    step(1'b1, OP_BR, 1'b0, 1'b1, S_I1, SRI | ERA | ECP, "br");
    step(1'b1, OP_CLR, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "br_next");
    step(1'b1, OP_CLR, 1'b0, 1'b1, S_I1, EAC | AOP_CLR | SCP | ERA, "clr");
    step(1'b1, OP_DEC, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "clr_next");
    step(1'b1, OP_DEC, 1'b1, 1'b1, S_I1, EAC | AOP_DEC | SCP | ERA, "dec");
    step(1'b1, OP_ST, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "dec_next");

    // ST with three wait cycles; co is scrambled to show O0 uses the latched opcode.
    step(1'b1, OP_ST, 1'b0, 1'b0, S_I1, SRI | ERA, "st_i1");
    step(1'b1, OP_HALT, 1'b0, 1'b0, S_O0, SAC | ESC, "st_wait1");
    step(1'b1, OP_LD, 1'b1, 1'b0, S_O0, SAC | ESC, "st_wait2");
    step(1'b1, OP_ADD, 1'b0, 1'b0, S_O0, SAC | ESC, "st_wait3");
    step(1'b1, OP_BR, 1'b0, 1'b1, S_O0, SAC | ESC, "st_ready");
    step(1'b1, OP_ADD, 1'b0, 1'b0, S_O1, SCP | ERA, "st_o1");
    step(1'b1, OP_ADD, 1'b0, 1'b0, S_I0, LEC, "fetch_wait");
    step(1'b1, OP_ADD, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "fetch_ready");
    step(1'b1, OP_ADD, 1'b0, 1'b0, S_I1, SRI | ERA, "add_i1");
    step(1'b1, OP_ADD, 1'b0, 1'b0, S_O0, LEC, "add_o0_wait");

    // Asynchronous reset in the middle of the ADD operand wait.
    #1;
    rstn   = 1'b0;
    e.st     = S_INI;
    e.vec    = NONE;
    e.chk_nr = 1'b0;
    e.nst    = 3'd0;
    e.nvec   = NONE;
    e.tag    = "async_reset";
    sb.push_back(e);
    #1;
    popAndCompare();
    step(1'b0, OP_ADD, 1'b0, 1'b1, S_INI, NONE, "reset_hold");
    step(1'b1, OP_ADD, 1'b0, 1'b1, S_INI, SCP | ERA, "reset_release");
    step(1'b1, OP_HALT, 1'b0, 1'b1, S_I0, LEC | ERI | INCP, "post_reset_i0");

    step(1'b1, OP_HALT, 1'b0, 1'b1, S_I1, STOP, "halt_i1");
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'(i % 8), 1'(i % 3), 1'(i % 2), S_HLT, STOP, "halt_hold");
    end
    step(1'b0, OP_LD, 1'b0, 1'b0, S_INI, NONE, "halt_reset",
         1'b1, S_INI, NONE);

    // mem_ready stays low: the waiting instance sits in I0, the other runs LD in 4 cycles.
    step(1'b1, OP_LD, 1'b0, 1'b0, S_INI, SCP | ERA, "nr_ini",
         1'b1, S_INI, SCP | ERA);
    step(1'b1, OP_LD, 1'b0, 1'b0, S_I0, LEC, "nr_i0",
         1'b1, S_I0, LEC | ERI | INCP);
    step(1'b1, OP_LD, 1'b0, 1'b0, S_I0, LEC, "nr_i1",
         1'b1, S_I1, SRI | ERA);
    step(1'b1, OP_LD, 1'b0, 1'b0, S_I0, LEC, "nr_o0",
         1'b1, S_O0, LEC | EAC);
    step(1'b1, OP_LD, 1'b0, 1'b0, S_I0, LEC, "nr_o1",
         1'b1, S_O1, SCP | ERA);
    step(1'b1, OP_LD, 1'b0, 1'b0, S_I0, LEC, "nr_back_i0",
         1'b1, S_I0, LEC | ERI | INCP);

    // HALT is left out so both instances keep cycling through every path.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      #1;
      co        = 3'($urandom_range(0, 6));
      z         = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      checkInvariants("rand_ready", obs_vec, state_o);
      checkInvariants("rand_noready", obs_nvec, n_state_o);
    end

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
